// File: rtl/md_sched.sv
// md_sched: EX-stage multiply/divide scheduler. Steers one HI/LO op to the
// shared divider or the pipelined multiplier, stalls EX while it runs, and
// holds the 64-bit {hi,lo} result until the pipeline consumes it.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req_i, is_div_i     EX request and unit select (sampled in IDLE)
//   signed_i            signedness, latched per unit on accept
//   flush_i, hold_i     kill current op / keep finished result
//   div_start_o         level start to divider while DIV_BUSY
//   div_annul_o         one-cycle divider cancel (flush or timeout)
//   div_signed_o        latched sign for divider
//   div_ready_i         divider result valid
//   div_result_i        divider {remainder, quotient}
//   mul_start_o         one-cycle multiplier launch pulse
//   mul_signed_o        latched sign for multiplier
//   mul_result_i        multiplier product {hi,lo}
//   stall_o             combinational IF/ID/EX freeze
//   result_valid_o      hi_o/lo_o hold a finished result
//   hi_o, lo_o          result[63:32], result[31:0]
//   busy_cnt_o          saturating cycles spent in current busy state
//   timeout_o           sticky divider timeout flag

module md_sched #(
    parameter int MUL_LAT = 2,
    parameter int DIV_MAX = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        is_div_i,
    input  logic        signed_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        mul_start_o,
    output logic        mul_signed_o,
    input  logic [63:0] mul_result_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [5:0]  busy_cnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_BUSY,
        S_MUL_BUSY,
        S_DONE
    } state_t;

    localparam logic [3:0]  MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [31:0] DIV_LAST = 32'(DIV_MAX - 1);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_busy_cnt;
    logic [3:0]  r_mul_cnt;
    logic [63:0] r_result;
    logic        r_timeout;
    logic        r_div_signed;
    logic        r_mul_signed;
    logic        r_mul_start;

    logic        w_accept;
    logic        w_in_div;
    logic        w_in_mul;
    logic        w_div_ready;
    logic        w_div_expire;
    logic        w_mul_last;

    assign w_in_div    = (r_state == S_DIV_BUSY);
    assign w_in_mul    = (r_state == S_MUL_BUSY);
    assign w_accept    = (r_state == S_IDLE) && req_i && !flush_i;
    assign w_div_ready = w_in_div && div_ready_i;
    assign w_mul_last  = w_in_mul && (r_mul_cnt == 4'd0);

    // A ready arriving on the last allowed cycle still wins over timeout.
    assign w_div_expire = w_in_div && !div_ready_i &&
                          ({26'd0, r_busy_cnt} == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_next = is_div_i ? S_DIV_BUSY : S_MUL_BUSY;
                end
            end
            S_DIV_BUSY: begin
                if (div_ready_i || w_div_expire) begin
                    w_next = S_DONE;
                end
            end
            S_MUL_BUSY: begin
                if (r_mul_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!hold_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Flush beats ready, expiry and hold.
        if (flush_i) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt   <= 6'd0;
            r_mul_cnt    <= 4'd0;
            r_div_signed <= 1'b0;
            r_mul_signed <= 1'b0;
            r_mul_start  <= 1'b0;
        end else begin
            r_mul_start <= w_accept && !is_div_i;
            if (w_accept) begin
                r_busy_cnt <= 6'd0;
                r_mul_cnt  <= MUL_LOAD;
                if (is_div_i) begin
                    r_div_signed <= signed_i;
                end else begin
                    r_mul_signed <= signed_i;
                end
            end else begin
                if ((w_in_div || w_in_mul) && (r_busy_cnt != 6'h3F)) begin
                    r_busy_cnt <= r_busy_cnt + 6'd1;
                end
                if (w_in_mul && (r_mul_cnt != 4'd0)) begin
                    r_mul_cnt <= r_mul_cnt - 4'd1;
                end
            end
        end
    end

    // Result survives flush; only a completed op overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= 64'd0;
            r_timeout <= 1'b0;
        end else if (!flush_i) begin
            if (w_div_ready) begin
                r_result <= div_result_i;
            end else if (w_div_expire) begin
                r_result  <= 64'd0;
                r_timeout <= 1'b1;
            end else if (w_mul_last) begin
                r_result <= mul_result_i;
            end
        end
    end

    assign div_start_o    = w_in_div;
    assign div_annul_o    = w_in_div && (flush_i || w_div_expire);
    assign div_signed_o   = r_div_signed;
    assign mul_start_o    = r_mul_start;
    assign mul_signed_o   = r_mul_signed;
    assign stall_o        = !flush_i &&
                            (((r_state == S_IDLE) && req_i) ||
                             w_in_div || w_in_mul);
    assign result_valid_o = (r_state == S_DONE);
    assign hi_o           = r_result[63:32];
    assign lo_o           = r_result[31:0];
    assign busy_cnt_o     = r_busy_cnt;
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized scoreboard bench for md_sched.
// Driver issues ops and queues expectations; a monitor checks them.

module tb_md_sched;

    localparam int MUL_LAT = 2;
    localparam int DIV_MAX = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, is_div_i, signed_i, flush_i, hold_i;
    logic        div_start_o, div_annul_o, div_signed_o, div_ready_i;
    logic [63:0] div_result_i, mul_result_i;
    logic        mul_start_o, mul_signed_o;
    logic        stall_o, result_valid_o, timeout_o;
    logic [31:0] hi_o, lo_o;
    logic [5:0]  busy_cnt_o;

    md_sched #(.MUL_LAT(MUL_LAT), .DIV_MAX(DIV_MAX)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .is_div_i(is_div_i), .signed_i(signed_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_ready_i(div_ready_i),
        .div_result_i(div_result_i),
        .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
        .mul_result_i(mul_result_i),
        .stall_o(stall_o), .result_valid_o(result_valid_o),
        .hi_o(hi_o), .lo_o(lo_o),
        .busy_cnt_o(busy_cnt_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        to;
        int          bc;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          gcyc    = 0;

    // Per-cycle expectations written by the driver, read by the monitor.
    logic        e_chk = 1'b0;
    logic        e_rst = 1'b0;
    logic        e_idle = 1'b0;
    logic        e_hilo = 1'b0;
    logic        e_sgn = 1'b0;
    logic        e_sgn_div = 1'b0;
    logic        e_sgn_val = 1'b0;
    logic [3:0]  e_ctl = 4'd0;
    logic [63:0] e_hilo_v = 64'd0;

    logic        m_timeout;
    logic [63:0] m_last;

    logic        prev_valid = 1'b0;
    logic [63:0] cur_res = 64'd0;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, gcyc);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Monitor: samples on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (e_rst) begin
            check("rst_ctl",
                  {stall_o, div_start_o, div_annul_o, div_signed_o,
                   mul_start_o, mul_signed_o, result_valid_o, timeout_o,
                   busy_cnt_o}, 64'd0);
            check("rst_hilo", {hi_o, lo_o}, 64'd0);
        end else begin
            if (e_chk)
                check("ctl", {stall_o, div_start_o, div_annul_o,
                              mul_start_o}, e_ctl);
            if (e_sgn)
                check("sign", e_sgn_div ? div_signed_o : mul_signed_o,
                      e_sgn_val);
            if (e_idle)
                check("idle_valid", result_valid_o, 1'b0);
            if (e_hilo)
                check("keep_hilo", {hi_o, lo_o}, e_hilo_v);
            if (result_valid_o && !prev_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid expected none (cycle %0d)",
                             gcyc);
                end else begin
                    e = q.pop_front();
                    check("result", {hi_o, lo_o}, e.res);
                    check("timeout", timeout_o, e.to);
                    check("busy_cnt", busy_cnt_o, 64'(e.bc));
                    check("done_cycle", 64'(gcyc), 64'(e.cyc));
                    cur_res <= e.res;
                end
            end else if (result_valid_o) begin
                check("hold_stable", {hi_o, lo_o}, cur_res);
            end
            if (q.size() > 0 && !result_valid_o && gcyc > q[0].cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL late_result: got no valid expected valid at cycle %0d (now %0d)",
                         q[0].cyc, gcyc);
                void'(q.pop_front());
            end
        end
        prev_valid <= result_valid_o;
    end

    // k: cycle of first ready (0 or >DIV_MAX = never), f: flush cycle
    // (0 = none), h: hold cycles in DONE, gap: idle cycles afterwards.
    task automatic do_op(input logic dv, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input int k, input int f, input int h,
                         input int gap);
        logic [63:0] good;
        logic [31:0] qs, rs;
        logic        to;
        int          d;
        int          ff;
        exp_t        e;
        if (dv) begin
            if (sg) begin
                qs = $signed(a) / $signed(b);
                rs = $signed(a) % $signed(b);
            end else begin
                qs = a / b;
                rs = a % b;
            end
            good = {rs, qs};
            if (k >= 1 && k <= DIV_MAX) begin
                d  = k + 1;
                to = 1'b0;
            end else begin
                d  = DIV_MAX + 1;
                to = 1'b1;
            end
        end else begin
            if (sg)
                good = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else
                good = {32'd0, a} * {32'd0, b};
            d  = MUL_LAT + 1;
            to = 1'b0;
        end
        ff    = (f >= d) ? 0 : f;
        e.res = to ? 64'd0 : good;
        e.to  = m_timeout | to;
        e.bc  = d - 1;

        @(posedge clk); #1;
        req_i = 1'b1; is_div_i = dv; signed_i = sg;
        flush_i = 1'b0; hold_i = 1'b0;
        div_ready_i = 1'($urandom);
        div_result_i = rnd64(); mul_result_i = rnd64();
        e_chk = 1'b1; e_ctl = 4'b1000;
        e_idle = 1'b1; e_hilo = 1'b0; e_sgn = 1'b0;
        if (ff == 0) begin
            e.cyc = gcyc + d;
            q.push_back(e);
        end

        for (int c = 1; c < d; c++) begin
            @(posedge clk); #1;
            e_idle  = 1'b0;
            flush_i = (c == ff);
            if (dv) begin
                div_ready_i  = (c == k);
                div_result_i = (c == k) ? good : rnd64();
                mul_result_i = rnd64();
            end else begin
                div_ready_i  = 1'($urandom);
                div_result_i = rnd64();
                mul_result_i = (c == MUL_LAT) ? good : rnd64();
            end
            e_ctl = {!flush_i, dv,
                     dv && (flush_i || (to && c == DIV_MAX)),
                     !dv && c == 1};
            e_sgn = 1'b1; e_sgn_div = dv; e_sgn_val = sg;
            if (flush_i) begin
                @(posedge clk); #1;
                req_i = 1'b0; flush_i = 1'b0;
                div_ready_i = dv;
                div_result_i = rnd64();
                e_ctl = 4'd0; e_sgn = 1'b0;
                e_idle = 1'b1; e_hilo = 1'b1; e_hilo_v = m_last;
                return;
            end
        end

        for (int c = d; c <= d + h; c++) begin
            @(posedge clk); #1;
            flush_i = 1'b0; req_i = 1'b1;
            hold_i = (c < d + h);
            div_ready_i = 1'($urandom);
            div_result_i = rnd64(); mul_result_i = rnd64();
            e_ctl = 4'd0; e_sgn = 1'b0; e_idle = 1'b0;
        end
        m_last    = e.res;
        m_timeout = e.to;

        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            req_i = 1'b0; hold_i = 1'b0;
            div_ready_i = 1'($urandom);
            e_ctl = 4'd0; e_idle = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by time 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        dv, sg;
        logic [31:0] a, b;
        int          k, f;

        rst = 1'b1;
        req_i = 1'b0; is_div_i = 1'b0; signed_i = 1'b0;
        flush_i = 1'b0; hold_i = 1'b0; div_ready_i = 1'b0;
        div_result_i = 64'd0; mul_result_i = 64'd0;
        m_timeout = 1'b0; m_last = 64'd0;
        e_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; e_rst = 1'b0;

        do_op(1'b1, 1'b0, 32'd100, 32'd7, 34, 0, 0, 0);
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 1);
        do_op(1'b1, 1'b1, 32'hFFFF_FFCE, 32'd7, 20, 10, 0, 0);
        do_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0, 3, 0);

        for (int i = 0; i < 60; i++) begin
            dv = 1'($urandom);
            sg = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
            if (b == 32'd0) b = 32'd1;
            if (sg && b == 32'hFFFF_FFFF) b = 32'd3;
            k = ($urandom_range(0, 99) < 15) ? 0 :
                int'($urandom_range(1, DIV_MAX));
            f = ($urandom_range(0, 99) < 20) ?
                int'($urandom_range(1, DIV_MAX)) : 0;
            do_op(dv, sg, a, b, k, f, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
        end

        do_op(1'b1, 1'b0, 32'd55, 32'd5, 0, 0, 1, 1);
        do_op(1'b0, 1'b0, 32'd6, 32'd7, 0, 0, 0, 0);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        req_i = 1'b1; is_div_i = 1'b0; signed_i = 1'b1;
        flush_i = 1'b0; hold_i = 1'b0; div_ready_i = 1'b0;
        e_chk = 1'b1; e_ctl = 4'b1000; e_idle = 1'b1;
        e_hilo = 1'b0; e_sgn = 1'b0;
        @(posedge clk); #1;
        e_chk = 1'b0; e_idle = 1'b0;
        #2;
        rst = 1'b1; req_i = 1'b0; e_rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; e_rst = 1'b0;
        m_timeout = 1'b0; m_last = 64'd0;

        do_op(1'b1, 1'b0, 32'd1000, 32'd33, 5, 0, 0, 0);
        do_op(1'b0, 1'b0, 32'd12345, 32'd678, 0, 0, 0, 2);

        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
